// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : state and access-length codes for the RAM port arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Both 2'b10 and 2'b11 select a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_byte_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_byte_seq : byte counter, wrapping address incrementer, little-endian read assembler
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_byte_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              adv,
  input  logic              cap,
  input  logic [7:0]        din,
  output logic [2:0]        cnt,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       asm_nxt
);

  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_asm;
  logic [1:0]        w_idx;

  // A captured byte belongs to the address issued one cycle earlier.
  assign w_idx = r_cnt[1:0] - 2'd1;
  assign cnt   = r_cnt;
  assign addr  = r_base + {{(ADDR_W-3){1'b0}}, r_cnt};

  always_comb begin
    asm_nxt = r_asm;
    if (cap) asm_nxt[{w_idx, 3'b000} +: 8] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 3'd0;
      r_base <= '0;
      r_asm  <= 32'd0;
    end else if (start) begin
      r_cnt  <= 3'd0;
      r_base <= base;
      r_asm  <= 32'd0;
    end else begin
      if (adv) r_cnt <= r_cnt + 3'd1;
      if (cap) r_asm <= asm_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one byte-wide RAM port between IF fetches and MEM loads/stores
// Option macro MEM_ARB_FAIR_EN: alternate grants when both sides request. Revision: 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_abort_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  output logic              busy_o
);

  arb_state_t        r_state, w_state_nxt;
  logic              r_owner_mem;
  logic [2:0]        r_nbytes;
  logic [31:0]       r_wdata;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;

  logic              w_if_want, w_pick_mem, w_grant, w_abort, w_rd_last;
  logic [2:0]        w_cnt;
  logic [ADDR_W-1:0] w_seq_addr;
  logic [31:0]       w_asm_nxt;

  assign w_if_want = if_req_i & ~if_abort_i;
  assign w_grant   = (r_state == ARB_IDLE) & (mem_req_i | w_if_want);

`ifdef MEM_ARB_FAIR_EN
  logic r_last_mem;
  assign w_pick_mem = mem_req_i & ~(w_if_want & r_last_mem);

  always_ff @(posedge clk) begin
    if (rst)          r_last_mem <= 1'b0;
    else if (w_grant) r_last_mem <= w_pick_mem;
  end
`else
  assign w_pick_mem = mem_req_i;
`endif

  // Only an IF read can be cancelled; MEM accesses always run to completion.
  assign w_abort   = (r_state == ARB_RD) & ~r_owner_mem & if_abort_i;
  assign w_rd_last = (r_state == ARB_RD) & (w_cnt == r_nbytes) & ~w_abort;

  mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (w_grant),
    .base    (w_pick_mem ? mem_addr_i : if_addr_i),
    .adv     ((r_state == ARB_RD) | (r_state == ARB_WR)),
    .cap     ((r_state == ARB_RD) & (w_cnt != 3'd0)),
    .din     (ram_din_i),
    .cnt     (w_cnt),
    .addr    (w_seq_addr),
    .asm_nxt (w_asm_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant) w_state_nxt = (w_pick_mem & mem_wr_i) ? ARB_WR : ARB_RD;
      ARB_RD: begin
        if (w_abort)                   w_state_nxt = ARB_IDLE;
        else if (w_cnt == r_nbytes)    w_state_nxt = ARB_DONE;
      end
      ARB_WR:   if (w_cnt == r_nbytes - 3'd1) w_state_nxt = ARB_DONE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner_mem <= 1'b0;
      r_nbytes    <= 3'd0;
      r_wdata     <= 32'd0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner_mem <= w_pick_mem;
        r_nbytes    <= w_pick_mem ? len_bytes(mem_len_i) : 3'd4;
        r_wdata     <= mem_wdata_i;
      end
      if (w_rd_last) begin
        if (r_owner_mem) r_mem_rdata <= w_asm_nxt;
        else             r_if_data   <= w_asm_nxt;
      end
    end
  end

  // The extra RD cycle after the last address only waits for the final byte.
  always_comb begin
    ram_addr_o = '0;
    ram_dout_o = 8'd0;
    ram_wr_o   = 1'b0;
    if (r_state == ARB_WR) begin
      ram_addr_o = w_seq_addr;
      ram_dout_o = r_wdata[{w_cnt[1:0], 3'b000} +: 8];
      ram_wr_o   = 1'b1;
    end else if ((r_state == ARB_RD) && (w_cnt < r_nbytes)) begin
      ram_addr_o = w_seq_addr;
    end
  end

  assign if_done_o   = (r_state == ARB_DONE) & ~r_owner_mem;
  assign mem_done_o  = (r_state == ARB_DONE) &  r_owner_mem;
  assign busy_o      = (r_state != ARB_IDLE);
  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed scenarios plus random traffic against a transaction-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0, if_abort_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic        mem_req_i = 1'b0, mem_wr_i = 1'b0;
  logic [1:0]  mem_len_i = 2'd0;
  logic [31:0] mem_addr_i = 32'd0, mem_wdata_i = 32'd0;
  logic [7:0]  ram_din_i = 8'd0;
  logic [31:0] if_data_o, mem_rdata_o, ram_addr_o;
  logic        if_done_o, mem_done_o, ram_wr_o, busy_o;
  logic [7:0]  ram_dout_o;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_abort_i(if_abort_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_din_i(ram_din_i), .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o),
    .ram_wr_o(ram_wr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM seen by the DUT, and the model's own independent copy of it.
  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = init_byte(32'(i));
      ref_mem[i] = init_byte(32'(i));
    end
  end

  always @(posedge clk) begin
    ram_din_i <= ram[ram_addr_o[15:0]];
    if (ram_wr_o) ram[ram_addr_o[15:0]] <= ram_dout_o;
  end

  task automatic preset(input logic [31:0] a, input logic [7:0] b);
    ram[a[15:0]]     = b;
    ref_mem[a[15:0]] = b;
  endtask

  // Transaction-level model: one access in flight, described by grant cycle and byte count.
  bit          m_act = 1'b0, m_mem = 1'b0, m_wr = 1'b0, m_last_mem = 1'b0;
  int          m_t = 0, m_n = 0;
  logic [31:0] m_base = 0, m_wdata = 0, m_rval = 0;
  logic [31:0] e_if_data = 0, e_mem_rdata = 0;

  always @(negedge clk) begin
    int          o;
    bit          ifw, pick_mem, e_wr, e_ifd, e_memd, e_busy;
    logic [31:0] e_addr;
    logic [7:0]  e_dout;
    o = cycle - m_t;
    e_addr = 0; e_dout = 0; e_wr = 0; e_ifd = 0; e_memd = 0; e_busy = m_act;
    if (m_act) begin
      if (o >= 1 && o <= m_n) begin
        e_addr = m_base + 32'(o - 1);
        if (m_wr) begin
          e_wr   = 1;
          e_dout = m_wdata[8*(o-1) +: 8];
        end
      end
      if ((m_wr && o == m_n + 1) || (!m_wr && o == m_n + 2)) begin
        if (m_mem) begin
          e_memd = 1;
          if (!m_wr) e_mem_rdata = m_rval;
        end else begin
          e_ifd     = 1;
          e_if_data = m_rval;
        end
      end
    end
    check("ram_addr",  ram_addr_o,        e_addr);
    check("ram_wr",    32'(ram_wr_o),     32'(e_wr));
    check("ram_dout",  32'(ram_dout_o),   32'(e_dout));
    check("if_done",   32'(if_done_o),    32'(e_ifd));
    check("mem_done",  32'(mem_done_o),   32'(e_memd));
    check("busy",      32'(busy_o),       32'(e_busy));
    check("if_data",   if_data_o,         e_if_data);
    check("mem_rdata", mem_rdata_o,       e_mem_rdata);

    if (e_wr) ref_mem[e_addr[15:0]] = e_dout;
    if (rst) begin
      m_act = 0; m_last_mem = 0; e_if_data = 0; e_mem_rdata = 0;
    end else if (m_act) begin
      if (e_ifd || e_memd)                 m_act = 0;
      else if (!m_mem && if_abort_i)       m_act = 0;
    end else begin
      ifw = if_req_i && !if_abort_i;
      if (mem_req_i || ifw) begin
`ifdef MEM_ARB_FAIR_EN
        pick_mem = mem_req_i && !(ifw && m_last_mem);
`else
        pick_mem = mem_req_i;
`endif
        m_act = 1; m_t = cycle; m_mem = pick_mem; m_last_mem = pick_mem;
        if (pick_mem) begin
          m_wr = mem_wr_i; m_base = mem_addr_i; m_wdata = mem_wdata_i;
          m_n  = (mem_len_i == 2'b00) ? 1 : (mem_len_i == 2'b01) ? 2 : 4;
        end else begin
          m_wr = 0; m_base = if_addr_i; m_n = 4;
        end
        m_rval = 0;
        if (!m_wr)
          for (int k = 0; k < m_n; k++) begin
            logic [31:0] a;
            a = m_base + 32'(k);
            m_rval = m_rval | (32'(ref_mem[a[15:0]]) << (8 * k));
          end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit on_mem, input string name, output int at);
    bit seen;
    seen = 0;
    at = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (on_mem ? mem_done_o : if_done_o) begin
        seen = 1;
        at = cycle;
      end
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] new_pc();
    return 32'h100 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    int t, d, d2, if_cnt, mem_cnt, diff;
    bit d_if, d_mem;
    step(); step();
    rst = 1'b0;
    step();

    // 1: IF fetch of a known instruction word.
    preset(32'h100, 8'h13); preset(32'h101, 8'h05); preset(32'h102, 8'h00); preset(32'h103, 8'h00);
    if_req_i = 1; if_addr_i = 32'h100; t = cycle;
    wait_done(0, "t1", d);
    check("t1_lat", 32'(d - t), 32'd6);
    check("t1_data", if_data_o, 32'h0000_0513);
    step(); if_req_i = 0; step();

    // 2: simultaneous IF and MEM byte load; MEM first, IF after the dead DONE cycle.
    preset(32'h1004, 8'hAB);
    if_req_i = 1; if_addr_i = 32'h200;
    mem_req_i = 1; mem_wr_i = 0; mem_len_i = 2'b00; mem_addr_i = 32'h1004; t = cycle;
    wait_done(1, "t2_mem", d);
    check("t2_mem_lat", 32'(d - t), 32'd3);
    check("t2_mem_data", mem_rdata_o, 32'h0000_00AB);
    step(); mem_req_i = 0;
    wait_done(0, "t2_if", d2);
    check("t2_if_lat", 32'(d2 - t), 32'd10);
    step(); if_req_i = 0; step();

    // 3: half-word store.
    mem_req_i = 1; mem_wr_i = 1; mem_len_i = 2'b01; mem_addr_i = 32'h30000; mem_wdata_i = 32'h1234_ABCD; t = cycle;
    wait_done(1, "t3", d);
    check("t3_lat", 32'(d - t), 32'd3);
    step(); mem_req_i = 0; mem_wr_i = 0;
    check("t3_b0", 32'(ram[16'h0000]), 32'h0000_00CD);
    check("t3_b1", 32'(ram[16'h0001]), 32'h0000_00AB);
    step();

    // 4: abort an IF read while a MEM load waits.
    preset(32'h1010, 8'h3C);
    if_req_i = 1; if_addr_i = 32'h140; t = cycle;
    step(); mem_req_i = 1; mem_wr_i = 0; mem_len_i = 2'b00; mem_addr_i = 32'h1010;
    step(); step(); if_abort_i = 1;
    step(); if_abort_i = 0; if_req_i = 0;
    wait_done(1, "t4", d);
    check("t4_lat", 32'(d - t), 32'd7);
    check("t4_data", mem_rdata_o, 32'h0000_003C);
    step(); mem_req_i = 0; step();

    // 5: reset in the middle of a word store, then a wrapping word load.
    mem_req_i = 1; mem_wr_i = 1; mem_len_i = 2'b10; mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEAD_BEEF;
    step(); step(); rst = 1; mem_req_i = 0; mem_wr_i = 0;
    step(); rst = 0;
    @(negedge clk);
    check("t5_wr_after_rst", 32'(ram_wr_o), 32'd0);
    check("t5_busy_after_rst", 32'(busy_o), 32'd0);
    check("t5_b1", 32'(ram[16'h2001]), 32'h0000_00BE);
    check("t5_b2", 32'(ram[16'h2002]), 32'(init_byte(32'h2002)));
    step();
    preset(32'hFFFF_FFFE, 8'hFE); preset(32'hFFFF_FFFF, 8'hFF); preset(32'h0, 8'h00); preset(32'h1, 8'h01);
    mem_req_i = 1; mem_len_i = 2'b10; mem_addr_i = 32'hFFFF_FFFE; t = cycle;
    wait_done(1, "t5", d);
    check("t5_lat", 32'(d - t), 32'd6);
    check("t5_wrap_data", mem_rdata_o, 32'h0100_FFFE);
    step(); mem_req_i = 0; step(); step();

    // 6: both requests held continuously.
    mem_req_i = 1; mem_wr_i = 0; mem_len_i = 2'b00; mem_addr_i = 32'h1020;
    if_req_i = 1; if_addr_i = 32'h180;
    if_cnt = 0; mem_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (if_done_o) if_cnt++;
      if (mem_done_o) mem_cnt++;
    end
    step(); mem_req_i = 0; if_req_i = 0;
    diff = (if_cnt > mem_cnt) ? if_cnt - mem_cnt : mem_cnt - if_cnt;
`ifdef MEM_ARB_FAIR_EN
    check("t6_if_served", 32'(if_cnt > 0), 32'd1);
    check("t6_alternate", 32'(diff <= 1), 32'd1);
`else
    check("t6_if_starved", 32'(if_cnt), 32'd0);
    check("t6_mem_count", 32'(mem_cnt), 32'd25);
`endif
    step(); step();

    // Random traffic with aborts and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      d_if = if_done_o; d_mem = mem_done_o;
      step();
      rst = ($urandom_range(0, 299) == 0);
      if_abort_i = 0;
      if (rst) begin
        if_req_i = 0; mem_req_i = 0;
      end else begin
        if (mem_req_i && d_mem) mem_req_i = 0;
        if (!mem_req_i && $urandom_range(0, 4) == 0) begin
          mem_req_i   = 1;
          mem_wr_i    = 1'($urandom_range(0, 1));
          mem_len_i   = 2'($urandom_range(0, 3));
          mem_addr_i  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                    : 32'h1000 + 32'($urandom_range(0, 255));
          mem_wdata_i = $urandom;
        end
        if (if_req_i && d_if) if_req_i = 0;
        if (if_req_i && $urandom_range(0, 15) == 0) begin
          if_abort_i = 1; if_addr_i = new_pc();
        end else if (!if_req_i && $urandom_range(0, 2) == 0) begin
          if_req_i = 1; if_addr_i = new_pc();
        end
      end
    end
    step(); rst = 0; if_req_i = 0; mem_req_i = 0; if_abort_i = 0;
    repeat (20) step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
